// File: rtl/dsu_thread_debug_ctrl.sv
// dsu_thread_debug_ctrl
//   Per-thread debug controller of the core DSU. Holds the breakpoint
//   address/enable registers feeding the breakpoint comparator. Turns
//   comparator hits, host halt/resume/step commands and issue events into
//   per-thread stop requests for the scheduler. Each completed halt is
//   reported once to the host as a stop event with a cause code.
//
// Ports
//   clk, reset             core clock, asynchronous active-high reset
//   dsu_enable             global debug enable (low: all threads run, hits masked)
//   cfg_bp_*               breakpoint register write port (we/idx/addr/en)
//   host_cmd_*             host command strobe, 00 halt 01 resume 10 step 11 ignored
//   host_thread_id         command target thread
//   is_instruction_valid   scheduler issued an instruction this cycle
//   is_thread_id           thread of the issued instruction
//   bp_hit                 comparator hit for the issued instruction
//   dsu_breakpoint[_enable] breakpoint addresses / enables
//   dsu_thread_stop        scheduler must not issue from the thread
//   dsu_thread_halted      thread is halted
//   dsu_stop_event         one-cycle halt report, with thread id and cause
//                          (00 host halt, 01 breakpoint, 10 step done)
module dsu_thread_debug_ctrl #(
  parameter int unsigned THREAD_NUMB  = 8,
  parameter int unsigned BP_NUMB      = 8,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dsu_enable,
  input  logic                           cfg_bp_we,
  input  logic [$clog2(BP_NUMB)-1:0]     cfg_bp_idx,
  input  logic [ADDR_WIDTH-1:0]          cfg_bp_addr,
  input  logic                           cfg_bp_en,
  input  logic                           host_cmd_valid,
  input  logic [1:0]                     host_cmd,
  input  logic [$clog2(THREAD_NUMB)-1:0] host_thread_id,
  input  logic                           is_instruction_valid,
  input  logic [$clog2(THREAD_NUMB)-1:0] is_thread_id,
  input  logic                           bp_hit,
  output logic [ADDR_WIDTH-1:0]          dsu_breakpoint [BP_NUMB],
  output logic [BP_NUMB-1:0]             dsu_breakpoint_enable,
  output logic [THREAD_NUMB-1:0]         dsu_thread_stop,
  output logic [THREAD_NUMB-1:0]         dsu_thread_halted,
  output logic                           dsu_stop_event,
  output logic [$clog2(THREAD_NUMB)-1:0] dsu_stop_thread_id,
  output logic [1:0]                     dsu_stop_cause
);

  localparam int unsigned TID_W = $clog2(THREAD_NUMB);
  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [1:0] CAUSE_HOST = 2'b00;
  localparam logic [1:0] CAUSE_BP   = 2'b01;
  localparam logic [1:0] CAUSE_STEP = 2'b10;

  localparam logic [1:0] CMD_HALT   = 2'b00;
  localparam logic [1:0] CMD_RESUME = 2'b01;
  localparam logic [1:0] CMD_STEP   = 2'b10;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;

  state_t               state_q [THREAD_NUMB];
  state_t               state_d [THREAD_NUMB];
  logic [CNT_W-1:0]     cnt_q   [THREAD_NUMB];
  logic [CNT_W-1:0]     cnt_d   [THREAD_NUMB];
  logic [1:0]           cause_q [THREAD_NUMB];
  logic [1:0]           cause_d [THREAD_NUMB];
  logic [THREAD_NUMB-1:0] skip_q, skip_d, pend_q, pend_d;
  logic [THREAD_NUMB-1:0] leave, eligible, stop_d, halted_d;
  logic                   ev_d;
  logic [TID_W-1:0]       ev_id_d;
  logic [1:0]             ev_cause_d;

  // Breakpoint registers: writable at any time, unaffected by dsu_enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BP_NUMB; i++) dsu_breakpoint[i] <= '0;
      dsu_breakpoint_enable <= '0;
    end else if (cfg_bp_we) begin
      dsu_breakpoint[cfg_bp_idx]        <= cfg_bp_addr;
      dsu_breakpoint_enable[cfg_bp_idx] <= cfg_bp_en;
    end
  end

  always_comb begin
    skip_d     = skip_q;
    pend_d     = pend_q;
    leave      = '0;
    stop_d     = '0;
    halted_d   = '0;
    ev_d       = 1'b0;
    ev_id_d    = '0;
    ev_cause_d = '0;
    for (int unsigned t = 0; t < THREAD_NUMB; t++) begin
      logic issue, hit, cmd_halt, cmd_resume, cmd_step;
      state_d[t] = state_q[t];
      cnt_d[t]   = cnt_q[t];
      cause_d[t] = cause_q[t];
      issue      = is_instruction_valid && (is_thread_id == TID_W'(t));
      hit        = issue && bp_hit && !skip_q[t] && dsu_enable;
      cmd_halt   = host_cmd_valid && (host_thread_id == TID_W'(t)) && (host_cmd == CMD_HALT);
      cmd_resume = host_cmd_valid && (host_thread_id == TID_W'(t)) && (host_cmd == CMD_RESUME);
      cmd_step   = host_cmd_valid && (host_thread_id == TID_W'(t)) && (host_cmd == CMD_STEP);

      if (issue) skip_d[t] = 1'b0;

      unique case (state_q[t])
        RUN: begin
          if (hit || cmd_halt) begin
            state_d[t] = DRAIN;
            cnt_d[t]   = CNT_W'(DRAIN_CYCLES - 1);
            cause_d[t] = hit ? CAUSE_BP : CAUSE_HOST;
          end
        end
        DRAIN: begin
          if (cnt_q[t] == '0) begin
            state_d[t] = HALTED;
            pend_d[t]  = 1'b1;
          end else begin
            cnt_d[t] = cnt_q[t] - 1'b1;
          end
        end
        HALTED: begin
          if (cmd_resume || cmd_step) begin
            state_d[t] = cmd_step ? STEP : RUN;
            leave[t]   = 1'b1;
            pend_d[t]  = 1'b0;
            // Re-execute the trapping PC once without hitting the same breakpoint.
            if (cause_q[t] == CAUSE_BP) skip_d[t] = 1'b1;
          end
        end
        STEP: begin
          if (issue) begin
            state_d[t] = DRAIN;
            cnt_d[t]   = CNT_W'(DRAIN_CYCLES - 1);
            cause_d[t] = hit ? CAUSE_BP : CAUSE_STEP;
          end
        end
        default: state_d[t] = RUN;
      endcase

      if (!dsu_enable) begin
        state_d[t] = RUN;
        skip_d[t]  = 1'b0;
        pend_d[t]  = 1'b0;
      end

      stop_d[t]   = (state_d[t] == DRAIN) || (state_d[t] == HALTED);
      halted_d[t] = (state_d[t] == HALTED);
    end

    // Lowest-index pending thread reports; a thread leaving HALTED this
    // cycle is excluded so no event refers to a thread already running.
    eligible = pend_q & ~leave & {THREAD_NUMB{dsu_enable}};
    for (int unsigned t = 0; t < THREAD_NUMB; t++) begin
      if (eligible[t] && !ev_d) begin
        ev_d       = 1'b1;
        ev_id_d    = TID_W'(t);
        ev_cause_d = cause_q[t];
        pend_d[t]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned t = 0; t < THREAD_NUMB; t++) begin
        state_q[t] <= RUN;
        cnt_q[t]   <= '0;
        cause_q[t] <= '0;
      end
      skip_q             <= '0;
      pend_q             <= '0;
      dsu_thread_stop    <= '0;
      dsu_thread_halted  <= '0;
      dsu_stop_event     <= 1'b0;
      dsu_stop_thread_id <= '0;
      dsu_stop_cause     <= '0;
    end else begin
      for (int unsigned t = 0; t < THREAD_NUMB; t++) begin
        state_q[t] <= state_d[t];
        cnt_q[t]   <= cnt_d[t];
        cause_q[t] <= cause_d[t];
      end
      skip_q            <= skip_d;
      pend_q            <= pend_d;
      dsu_thread_stop   <= stop_d;
      dsu_thread_halted <= halted_d;
      dsu_stop_event    <= ev_d;
      if (ev_d) begin
        dsu_stop_thread_id <= ev_id_d;
        dsu_stop_cause     <= ev_cause_d;
      end
    end
  end

endmodule

// File: tb/tb_dsu_thread_debug_ctrl.sv
// Testbench for dsu_thread_debug_ctrl: directed scenarios followed by a
// randomized run, all checked against a cycle-count based reference model.
module tb_dsu_thread_debug_ctrl;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dsu_enable = 1'b1;
  logic        cfg_bp_we = 1'b0;
  logic [2:0]  cfg_bp_idx = '0;
  logic [31:0] cfg_bp_addr = '0;
  logic        cfg_bp_en = 1'b0;
  logic        host_cmd_valid = 1'b0;
  logic [1:0]  host_cmd = '0;
  logic [2:0]  host_thread_id = '0;
  logic        is_instruction_valid = 1'b0;
  logic [2:0]  is_thread_id = '0;
  logic        bp_hit = 1'b0;
  logic [31:0] dsu_breakpoint [8];
  logic [7:0]  dsu_breakpoint_enable;
  logic [7:0]  dsu_thread_stop;
  logic [7:0]  dsu_thread_halted;
  logic        dsu_stop_event;
  logic [2:0]  dsu_stop_thread_id;
  logic [1:0]  dsu_stop_cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsu_thread_debug_ctrl #(
    .THREAD_NUMB(8), .BP_NUMB(8), .ADDR_WIDTH(32), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .dsu_enable(dsu_enable),
    .cfg_bp_we(cfg_bp_we), .cfg_bp_idx(cfg_bp_idx), .cfg_bp_addr(cfg_bp_addr),
    .cfg_bp_en(cfg_bp_en), .host_cmd_valid(host_cmd_valid), .host_cmd(host_cmd),
    .host_thread_id(host_thread_id), .is_instruction_valid(is_instruction_valid),
    .is_thread_id(is_thread_id), .bp_hit(bp_hit),
    .dsu_breakpoint(dsu_breakpoint), .dsu_breakpoint_enable(dsu_breakpoint_enable),
    .dsu_thread_stop(dsu_thread_stop), .dsu_thread_halted(dsu_thread_halted),
    .dsu_stop_event(dsu_stop_event), .dsu_stop_thread_id(dsu_stop_thread_id),
    .dsu_stop_cause(dsu_stop_cause)
  );

  // Reference model: a thread is stopped from the cycle its drain began
  // (m_ds) and halted once DC cycles have elapsed since then.
  longint      cyc;
  longint      m_ds [8];
  bit          m_stepping [8];
  bit [1:0]    m_cause [8];
  bit          m_skip [8];
  bit          m_pend [8];
  logic [31:0] m_bp [8];
  logic [7:0]  m_bpen;
  bit          m_ev;
  int          m_ev_id;
  bit [1:0]    m_ev_cause;

  function automatic logic [7:0] m_stop();
    for (int t = 0; t < 8; t++) m_stop[t] = (m_ds[t] >= 0);
  endfunction

  function automatic logic [7:0] m_halted();
    for (int t = 0; t < 8; t++) m_halted[t] = (m_ds[t] >= 0) && (cyc >= m_ds[t] + DC);
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int t = 0; t < 8; t++) begin
      m_ds[t] = -1; m_stepping[t] = 0; m_cause[t] = 0; m_skip[t] = 0; m_pend[t] = 0;
      m_bp[t] = '0;
    end
    m_bpen = '0; m_ev = 0; m_ev_id = 0; m_ev_cause = 0;
  endtask

  task automatic model_advance();
    bit lv [8];
    m_ev = 0;
    for (int t = 0; t < 8; t++) lv[t] = 0;
    if (!dsu_enable) begin
      for (int t = 0; t < 8; t++) begin
        m_ds[t] = -1; m_stepping[t] = 0; m_pend[t] = 0; m_skip[t] = 0;
      end
    end else begin
      for (int t = 0; t < 8; t++) begin
        bit issue, hit, ch, cr, cs, h;
        issue = is_instruction_valid && (int'(is_thread_id) == t);
        hit   = issue && bp_hit && !m_skip[t];
        ch = host_cmd_valid && (int'(host_thread_id) == t) && host_cmd == 2'd0;
        cr = host_cmd_valid && (int'(host_thread_id) == t) && host_cmd == 2'd1;
        cs = host_cmd_valid && (int'(host_thread_id) == t) && host_cmd == 2'd2;
        h  = (m_ds[t] >= 0) && (cyc >= m_ds[t] + DC);
        if (m_stepping[t]) begin
          if (issue) begin
            m_stepping[t] = 0; m_ds[t] = cyc + 1; m_cause[t] = hit ? 2'd1 : 2'd2;
          end
        end else if (m_ds[t] < 0) begin
          if (hit) begin m_ds[t] = cyc + 1; m_cause[t] = 2'd1; end
          else if (ch) begin m_ds[t] = cyc + 1; m_cause[t] = 2'd0; end
        end else if (h && (cr || cs)) begin
          lv[t] = 1; m_ds[t] = -1; m_stepping[t] = cs;
        end
        if (issue) m_skip[t] = 0;
        if (lv[t] && m_cause[t] == 2'd1) m_skip[t] = 1;
      end
      for (int t = 0; t < 8; t++) begin
        if (m_pend[t] && !lv[t] && !m_ev) begin
          m_ev = 1; m_ev_id = t; m_ev_cause = m_cause[t]; m_pend[t] = 0;
        end
      end
      for (int t = 0; t < 8; t++) begin
        if (lv[t]) m_pend[t] = 0;
        if (m_ds[t] >= 0 && cyc + 1 == m_ds[t] + DC) m_pend[t] = 1;
      end
    end
    if (cfg_bp_we) begin
      m_bp[cfg_bp_idx] = cfg_bp_addr;
      m_bpen[cfg_bp_idx] = cfg_bp_en;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle();
    cfg_bp_we = 0; host_cmd_valid = 0; is_instruction_valid = 0; bp_hit = 0;
  endtask

  task automatic host(input logic [1:0] cmd, input logic [2:0] tid);
    host_cmd_valid = 1; host_cmd = cmd; host_thread_id = tid;
  endtask

  task automatic issue(input logic [2:0] tid, input logic hit);
    is_instruction_valid = 1; is_thread_id = tid; bp_hit = hit;
  endtask

  // Idle cycles after a halt starts: halted on k=DC, event on k=DC+1.
  task automatic drain_and_report(input string name, input logic [2:0] tid,
                                  input logic [1:0] cause);
    for (int k = 1; k <= DC + 2; k++) begin
      tick();
      n_checks++;
      if (dsu_thread_halted[tid] !== (k >= DC)) begin
        n_fail++;
        $display("FAIL %s halted k=%0d: got %b expected %b", name, k, dsu_thread_halted[tid], k >= DC);
      end
      n_checks++;
      if (dsu_stop_event !== (k == DC + 1)) begin
        n_fail++;
        $display("FAIL %s event k=%0d: got %b expected %b", name, k, dsu_stop_event, k == DC + 1);
      end
      if (k == DC + 1) begin
        n_checks++;
        if (dsu_stop_thread_id !== tid || dsu_stop_cause !== cause) begin
          n_fail++;
          $display("FAIL %s report: got id %0d cause %b expected id %0d cause %b",
                   name, dsu_stop_thread_id, dsu_stop_cause, tid, cause);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; idle();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dsu_thread_stop !== 8'h00 || dsu_thread_halted !== 8'h00 || dsu_stop_event !== 1'b0 ||
        dsu_stop_thread_id !== 3'd0 || dsu_stop_cause !== 2'd0 || dsu_breakpoint_enable !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got stop %h halted %h ev %b id %0d cause %b bpen %h expected all 0",
               dsu_thread_stop, dsu_thread_halted, dsu_stop_event, dsu_stop_thread_id,
               dsu_stop_cause, dsu_breakpoint_enable);
    end
    reset = 0;
    model_reset();
    tick();
    n_checks++;
    if (dsu_thread_stop !== 8'h00 || dsu_breakpoint[3] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got stop %h bp3 %h expected 0 0", dsu_thread_stop, dsu_breakpoint[3]);
    end
  endtask

  task automatic test_bp_hit();
    cfg_bp_we = 1; cfg_bp_idx = 3'd3; cfg_bp_addr = 32'h0000_0400; cfg_bp_en = 1;
    tick(); idle();
    n_checks++;
    if (dsu_breakpoint[3] !== 32'h0000_0400 || dsu_breakpoint_enable !== 8'h08) begin
      n_fail++;
      $display("FAIL cfg_write: got %h/%h expected 00000400/08", dsu_breakpoint[3], dsu_breakpoint_enable);
    end
    issue(3'd2, 1); tick(); idle();
    n_checks++;
    if (dsu_thread_stop !== 8'h04 || dsu_thread_halted !== 8'h00) begin
      n_fail++;
      $display("FAIL bp_stop: got stop %h halted %h expected 04 00", dsu_thread_stop, dsu_thread_halted);
    end
    drain_and_report("bp_hit", 3'd2, 2'd1);
  endtask

  task automatic test_skip();
    host(2'd1, 3'd2); tick(); idle();
    n_checks++;
    if (dsu_thread_stop !== 8'h00) begin
      n_fail++; $display("FAIL resume_stop: got %h expected 00", dsu_thread_stop);
    end
    issue(3'd2, 1); tick(); idle();
    n_checks++;
    if (dsu_thread_stop !== 8'h00) begin
      n_fail++; $display("FAIL skip_rehit: got %h expected 00", dsu_thread_stop);
    end
    tick();
    issue(3'd2, 1); tick(); idle();
    n_checks++;
    if (dsu_thread_stop !== 8'h04) begin
      n_fail++; $display("FAIL second_hit: got %h expected 04", dsu_thread_stop);
    end
    drain_and_report("second_hit", 3'd2, 2'd1);
    host(2'd1, 3'd2); tick(); idle();
    issue(3'd2, 0); tick(); idle();
  endtask

  task automatic test_step();
    host(2'd0, 3'd5); tick(); idle();
    n_checks++;
    if (dsu_thread_stop !== 8'h20) begin
      n_fail++; $display("FAIL halt5_stop: got %h expected 20", dsu_thread_stop);
    end
    drain_and_report("halt5", 3'd5, 2'd0);
    host(2'd2, 3'd5); tick(); idle();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (dsu_thread_stop !== 8'h00 || dsu_thread_halted !== 8'h00) begin
        n_fail++;
        $display("FAIL step_running k=%0d: got stop %h halted %h expected 00 00", k, dsu_thread_stop, dsu_thread_halted);
      end
      tick();
    end
    issue(3'd5, 0); tick(); idle();
    n_checks++;
    if (dsu_thread_stop !== 8'h20) begin
      n_fail++; $display("FAIL step_restop: got %h expected 20", dsu_thread_stop);
    end
    drain_and_report("step_done", 3'd5, 2'd2);
    host(2'd1, 3'd5); tick(); idle();
  endtask

  task automatic test_back_to_back();
    host(2'd0, 3'd1); issue(3'd6, 1); tick(); idle();
    n_checks++;
    if (dsu_thread_stop !== 8'h42) begin
      n_fail++; $display("FAIL b2b_stop: got %h expected 42", dsu_thread_stop);
    end
    for (int k = 1; k <= DC + 3; k++) begin
      tick();
      if (k == DC) begin
        n_checks++;
        if (dsu_thread_halted !== 8'h42) begin
          n_fail++; $display("FAIL b2b_halted: got %h expected 42", dsu_thread_halted);
        end
      end
      n_checks++;
      if (dsu_stop_event !== (k == DC + 1 || k == DC + 2)) begin
        n_fail++; $display("FAIL b2b_event k=%0d: got %b", k, dsu_stop_event);
      end
      if (k == DC + 1 || k == DC + 2) begin
        n_checks++;
        if (dsu_stop_thread_id !== ((k == DC + 1) ? 3'd1 : 3'd6) ||
            dsu_stop_cause !== ((k == DC + 1) ? 2'd0 : 2'd1)) begin
          n_fail++;
          $display("FAIL b2b_order k=%0d: got id %0d cause %b", k, dsu_stop_thread_id, dsu_stop_cause);
        end
      end
    end
    host(2'd1, 3'd1); tick();
    host(2'd1, 3'd6); tick(); idle();
    issue(3'd6, 0); tick(); idle();
  endtask

  task automatic test_same_cycle_and_ignored();
    logic [1:0] cmds [3];
    cmds[0] = 2'd1; cmds[1] = 2'd2; cmds[2] = 2'd3;
    host(2'd0, 3'd0); issue(3'd0, 1); tick(); idle();
    drain_and_report("halt_and_hit", 3'd0, 2'd1);
    host(2'd1, 3'd0); tick(); idle();
    issue(3'd0, 0); tick(); idle();
    for (int i = 0; i < 3; i++) begin
      host(cmds[i], 3'd0); tick(); idle();
      n_checks++;
      if (dsu_thread_stop !== 8'h00 || dsu_thread_halted !== 8'h00) begin
        n_fail++;
        $display("FAIL ignored_cmd %b: got stop %h halted %h expected 00 00", cmds[i], dsu_thread_stop, dsu_thread_halted);
      end
    end
  endtask

  task automatic test_disable();
    host(2'd0, 3'd3); tick(); idle(); tick();
    n_checks++;
    if (dsu_thread_stop !== 8'h08) begin
      n_fail++; $display("FAIL drain3_stop: got %h expected 08", dsu_thread_stop);
    end
    dsu_enable = 0; tick(); dsu_enable = 1;
    n_checks++;
    if (dsu_thread_stop !== 8'h00 || dsu_thread_halted !== 8'h00) begin
      n_fail++; $display("FAIL disable_run: got stop %h halted %h expected 00 00", dsu_thread_stop, dsu_thread_halted);
    end
    for (int k = 0; k < DC + 2; k++) begin
      tick();
      n_checks++;
      if (dsu_stop_event !== 1'b0 || dsu_thread_stop !== 8'h00) begin
        n_fail++; $display("FAIL disable_quiet k=%0d: got ev %b stop %h expected 0 00", k, dsu_stop_event, dsu_thread_stop);
      end
    end
    n_checks++;
    if (dsu_breakpoint[3] !== 32'h0000_0400) begin
      n_fail++; $display("FAIL disable_bp_kept: got %h expected 00000400", dsu_breakpoint[3]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      idle();
      dsu_enable = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 5) == 0) host(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 0) issue(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 15) == 0) begin
        cfg_bp_we = 1; cfg_bp_idx = 3'($urandom_range(0, 7));
        cfg_bp_addr = $urandom; cfg_bp_en = 1'($urandom_range(0, 1));
      end
      tick();
      n_checks++;
      if (dsu_thread_stop !== m_stop()) begin
        n_fail++; $display("FAIL rand_stop c=%0d: got %h expected %h", c, dsu_thread_stop, m_stop());
      end
      n_checks++;
      if (dsu_thread_halted !== m_halted()) begin
        n_fail++; $display("FAIL rand_halted c=%0d: got %h expected %h", c, dsu_thread_halted, m_halted());
      end
      n_checks++;
      if (dsu_stop_event !== m_ev) begin
        n_fail++; $display("FAIL rand_event c=%0d: got %b expected %b", c, dsu_stop_event, m_ev);
      end else if (m_ev) begin
        n_checks++;
        if (int'(dsu_stop_thread_id) != m_ev_id || dsu_stop_cause !== m_ev_cause) begin
          n_fail++;
          $display("FAIL rand_report c=%0d: got id %0d cause %b expected id %0d cause %b",
                   c, dsu_stop_thread_id, dsu_stop_cause, m_ev_id, m_ev_cause);
        end
      end
      n_checks++;
      if (dsu_breakpoint_enable !== m_bpen || dsu_breakpoint[cfg_bp_idx] !== m_bp[cfg_bp_idx]) begin
        n_fail++;
        $display("FAIL rand_bp c=%0d: got en %h addr %h expected en %h addr %h", c,
                 dsu_breakpoint_enable, dsu_breakpoint[cfg_bp_idx], m_bpen, m_bp[cfg_bp_idx]);
      end
    end
    idle(); dsu_enable = 1;
  endtask

  task automatic test_reset_mid_step();
    dsu_enable = 0; tick(); dsu_enable = 1;
    host(2'd0, 3'd4); tick(); idle();
    repeat (DC + 1) tick();
    cfg_bp_we = 1; cfg_bp_idx = 3'd1; cfg_bp_addr = 32'hdead_beef; cfg_bp_en = 1;
    host(2'd2, 3'd4); tick(); idle();
    #3 reset = 1;
    #1;
    n_checks++;
    if (dsu_thread_stop !== 8'h00 || dsu_thread_halted !== 8'h00 || dsu_stop_event !== 1'b0 ||
        dsu_breakpoint_enable !== 8'h00 || dsu_breakpoint[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_step: got stop %h halted %h ev %b bpen %h bp1 %h expected all 0",
               dsu_thread_stop, dsu_thread_halted, dsu_stop_event, dsu_breakpoint_enable, dsu_breakpoint[1]);
    end
    #1 reset = 0;
    model_reset();
    tick();
  endtask

  initial begin
    test_reset();
    test_bp_hit();
    test_skip();
    test_step();
    test_back_to_back();
    test_same_cycle_and_ignored();
    test_disable();
    test_random();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
